// File: rtl/pq_pkg.sv
// pq_pkg: shared types and constants for the hardware priority queues and
// their request-side driver.
//   kv_t      : packed <key,value> pair, smaller key = higher priority
//   KEYINF    : key value marking an empty slot
//   KV_EMPTY  : pair returned when nothing was dequeued
//   pq_op_t   : driver operation codes (NOP/ENQ/DEQ/REPL)
package pq_pkg;

   localparam int PQ_CAPACITY = 15;

   typedef struct packed {
      logic [7:0] key;
      logic [7:0] val;
   } kv_t;

   localparam logic [7:0] KEYINF   = 8'hFF;
   localparam kv_t        KV_EMPTY = '{key: KEYINF, val: 8'h00};

   typedef enum logic [1:0] {
      OP_NOP  = 2'd0,
      OP_ENQ  = 2'd1,
      OP_DEQ  = 2'd2,
      OP_REPL = 2'd3
   } pq_op_t;

endpackage

// File: rtl/pq_driver.sv
// pq_driver: request-side sequencer for a hardware priority queue.
// Accepts one <key,value> op over a valid/ready request channel, issues it to
// the PQ as a single-cycle strobe, waits for the PQ to go idle and returns
// the result over a valid/ready response channel. Full/empty misuse is
// rejected without touching the PQ. One operation outstanding at a time.
//
// Ports:
//   clk, rst_n             clock, async active-low reset (PQ shares rst_n)
//   req_valid/req_ready    request handshake; req_op, req_kv request payload
//   rsp_valid/rsp_ready    response handshake; rsp_kv, rsp_err payload
//   pq_enq, pq_deq         strobes to the PQ (both high = replace)
//   pq_kv_in               pair presented to the PQ, held until next strobe
//   pq_kv_out              PQ head / dequeued pair
//   pq_busy, pq_full, pq_empty  PQ status
//   count                  shadow occupancy, saturating 0..CAPACITY
//
// Optional feature: define PQ_DRV_STATS_EN to add saturating 16-bit counters
// stat_enq (legal ENQ), stat_deq (legal DEQ/REPL), stat_err (rejected ops).
module pq_driver
   import pq_pkg::*;
#(
   parameter int CAPACITY = PQ_CAPACITY
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            req_valid,
   output logic                            req_ready,
   input  pq_op_t                          req_op,
   input  kv_t                             req_kv,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output kv_t                             rsp_kv,
   output logic                            rsp_err,
   output logic                            pq_enq,
   output logic                            pq_deq,
   output kv_t                             pq_kv_in,
   input  kv_t                             pq_kv_out,
   input  logic                            pq_busy,
   input  logic                            pq_full,
   input  logic                            pq_empty,
   output logic [$clog2(CAPACITY+1)-1:0]   count
`ifdef PQ_DRV_STATS_EN
   ,
   output logic [15:0]                     stat_enq,
   output logic [15:0]                     stat_deq,
   output logic [15:0]                     stat_err
`endif
);

   localparam int            CW    = $clog2(CAPACITY + 1);
   localparam logic [CW-1:0] CAP_C = CW'(CAPACITY);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t        state, state_d;
   pq_op_t        op_q, op_d;
   kv_t           kv_q, kv_d;
   kv_t           rsp_kv_d, kv_in_d;
   logic          rsp_err_d, enq_d, deq_d;
   logic [CW-1:0] count_d;
   logic          illegal;

   // The shadow count is checked alongside the PQ flags so a PQ whose status
   // lags (or a miswired flag) still cannot be over- or under-run.
   assign illegal = ((op_q == OP_ENQ) && (pq_full || count == CAP_C)) ||
                    ((op_q inside {OP_DEQ, OP_REPL}) && (pq_empty || count == '0));

   always_comb begin
      state_d   = state;
      op_d      = op_q;
      kv_d      = kv_q;
      rsp_kv_d  = rsp_kv;
      rsp_err_d = rsp_err;
      enq_d     = 1'b0;
      deq_d     = 1'b0;
      kv_in_d   = pq_kv_in;
      count_d   = count;
      unique case (state)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               op_d    = req_op;
               kv_d    = req_kv;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!pq_busy) begin
               if (illegal) begin
                  rsp_err_d = 1'b1;
                  rsp_kv_d  = KV_EMPTY;
                  state_d   = S_RESP;
               end else if (op_q == OP_NOP) begin
                  rsp_err_d = 1'b0;
                  rsp_kv_d  = KV_EMPTY;
                  state_d   = S_RESP;
               end else begin
                  enq_d     = (op_q inside {OP_ENQ, OP_REPL});
                  deq_d     = (op_q inside {OP_DEQ, OP_REPL});
                  kv_in_d   = kv_q;
                  rsp_err_d = 1'b0;
                  state_d   = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            // The PQ presents the dequeued pair on pq_kv_out once idle.
            if (!pq_busy) begin
               rsp_kv_d = (op_q == OP_ENQ) ? KV_EMPTY : pq_kv_out;
               if (op_q == OP_ENQ && count != CAP_C) count_d = count + 1'b1;
               if (op_q == OP_DEQ && count != '0)    count_d = count - 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         op_q      <= OP_NOP;
         kv_q      <= KV_EMPTY;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_kv    <= KV_EMPTY;
         rsp_err   <= 1'b0;
         pq_enq    <= 1'b0;
         pq_deq    <= 1'b0;
         pq_kv_in  <= KV_EMPTY;
         count     <= '0;
      end else begin
         state     <= state_d;
         op_q      <= op_d;
         kv_q      <= kv_d;
         // Handshake flags are registered from the next state so they line
         // up with the state the FSM is actually in.
         req_ready <= (state_d == S_IDLE);
         rsp_valid <= (state_d == S_RESP);
         rsp_kv    <= rsp_kv_d;
         rsp_err   <= rsp_err_d;
         pq_enq    <= enq_d;
         pq_deq    <= deq_d;
         pq_kv_in  <= kv_in_d;
         count     <= count_d;
      end
   end

`ifdef PQ_DRV_STATS_EN
   logic rej;
   assign rej = (state == S_ISSUE) && !pq_busy && illegal;

   // Counted from the registered strobes: each legal op strobes exactly once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_enq <= '0;
         stat_deq <= '0;
         stat_err <= '0;
      end else begin
         if (pq_enq && !pq_deq && stat_enq != '1) stat_enq <= stat_enq + 1'b1;
         if (pq_deq && stat_deq != '1)            stat_deq <= stat_deq + 1'b1;
         if (rej && stat_err != '1)               stat_err <= stat_err + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pq_driver.sv
module tb_pq_driver;
   import pq_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic req_valid = 1'b0, req_ready;
   pq_op_t req_op = OP_NOP;
   kv_t req_kv = KV_EMPTY;
   logic rsp_valid, rsp_ready = 1'b0;
   kv_t rsp_kv;
   logic rsp_err;
   logic pq_enq, pq_deq;
   kv_t pq_kv_in, pq_kv_out;
   logic pq_busy = 1'b0, pq_full, pq_empty;
   logic [3:0] count;
`ifdef PQ_DRV_STATS_EN
   logic [15:0] stat_enq, stat_deq, stat_err;
`endif

   always #5 clk = ~clk;

   pq_driver #(.CAPACITY(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_kv(req_kv),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_kv(rsp_kv), .rsp_err(rsp_err),
      .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kv_in(pq_kv_in), .pq_kv_out(pq_kv_out),
      .pq_busy(pq_busy), .pq_full(pq_full), .pq_empty(pq_empty), .count(count)
`ifdef PQ_DRV_STATS_EN
      , .stat_enq(stat_enq), .stat_deq(stat_deq), .stat_err(stat_err)
`endif
   );

   // ---------------- behavioural priority queue (environment) ----------------
   typedef kv_t arr_t [16];
   arr_t pq_arr;
   int   pq_n;
   logic pq_hold;
   kv_t  pq_held, pq_head;

   function automatic arr_t pq_next(input arr_t a, input int n, input logic e,
                                    input logic d, input kv_t kv);
      arr_t r = a;
      int   m = n;
      int   p = 0;
      if (d && m > 0) begin
         for (int i = 0; i < 15; i++) r[i] = r[i+1];
         m--;
      end
      if (e && m < 16) begin
         while (p < m && r[p].key <= kv.key) p++;
         for (int i = 15; i > p; i--) r[i] = r[i-1];
         r[p] = kv;
      end
      return r;
   endfunction

   assign pq_head   = (pq_n == 0) ? KV_EMPTY : pq_arr[0];
   assign pq_kv_out = pq_hold ? pq_held : pq_head;
   assign pq_full   = (pq_n == 15);
   assign pq_empty  = (pq_n == 0);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pq_n    <= 0;
         pq_hold <= 1'b0;
         pq_held <= KV_EMPTY;
      end else begin
         if (pq_enq || pq_deq) begin
            pq_arr <= pq_next(pq_arr, pq_n, pq_enq, pq_deq, pq_kv_in);
            pq_n   <= pq_n + (pq_enq ? 1 : 0) - ((pq_deq && pq_n > 0) ? 1 : 0);
         end
         // keep the dequeued pair visible while the PQ reports busy
         if (pq_deq) begin
            pq_hold <= 1'b1;
            pq_held <= pq_head;
         end else if (!pq_busy) begin
            pq_hold <= 1'b0;
         end
      end
   end

   // ---------------- bookkeeping ----------------
   int cyc = 0, n_enq_str = 0, n_deq_str = 0;
   int checks = 0, failures = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n && pq_enq) n_enq_str <= n_enq_str + 1;
      if (rst_n && pq_deq) n_deq_str <= n_deq_str + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard + monitor ----------------
   typedef struct { kv_t kv; logic err; int lat; } exp_t;
   exp_t sb[$];

   initial begin
      int   acc_cyc = 0;
      logic seen = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (req_valid && req_ready) begin
               acc_cyc = cyc;
               seen    = 1'b0;
            end
            if (rsp_valid) begin
               if (sb.size() == 0) begin
                  chk("rsp_unexpected", 32'd1, 32'd0);
               end else begin
                  e = sb[0];
                  if (!seen) begin
                     seen = 1'b1;
                     chk("rsp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
                  end
                  chk("rsp_payload", 32'({rsp_err, rsp_kv}), 32'({e.err, e.kv}));
                  if (rsp_ready) void'(sb.pop_front());
               end
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Issues one op with the given ISSUE/WAIT busy stalls and response
   // back-pressure; expected response, count and timing are pushed up front.
   task automatic do_op(input pq_op_t op, input kv_t kv, input logic e_err,
                        input kv_t e_kv, input int e_cnt,
                        input int is, input int ws, input int rh);
      logic legal;
      int   e0, d0;
      exp_t x;
      legal = !e_err && (op != OP_NOP);
      x.kv  = e_kv;
      x.err = e_err;
      x.lat = legal ? (3 + is + ws) : (2 + is);
      sb.push_back(x);
      e0 = n_enq_str;
      d0 = n_deq_str;
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_op = op; req_kv = kv; pq_busy = (is > 0);
      step;
      req_valid = 1'b0; req_op = OP_NOP; req_kv = KV_EMPTY;
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      repeat (is) begin
         step;
         chk("req_ready_issue_stall", 32'(req_ready), 32'd0);
      end
      pq_busy = 1'b0;
      step;
      if (legal) begin
         chk("pq_kv_in", 32'(pq_kv_in), 32'(kv));
         pq_busy = (ws > 0);
         repeat (ws) begin
            step;
            chk("req_ready_wait_stall", 32'(req_ready), 32'd0);
         end
         pq_busy = 1'b0;
         step;
      end
      repeat (rh) begin
         step;
         chk("req_ready_rsp_stall", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      step;
      rsp_ready = 1'b0;
      chk("count", 32'(count), 32'(e_cnt));
      chk("enq_strobes", 32'(n_enq_str - e0),
          32'((legal && (op == OP_ENQ || op == OP_REPL)) ? 1 : 0));
      chk("deq_strobes", 32'(n_deq_str - d0),
          32'((legal && (op == OP_DEQ || op == OP_REPL)) ? 1 : 0));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
      chk({tag, "_rsp_kv"},    32'(rsp_kv),    32'h0000FF00);
      chk({tag, "_strobes"},   32'({pq_enq, pq_deq}), 32'd0);
      chk({tag, "_pq_kv_in"},  32'(pq_kv_in),  32'h0000FF00);
      chk({tag, "_count"},     32'(count),     32'd0);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("req_ready_before_edge", 32'(req_ready), 32'd0);
      step;
      chk("req_ready_after_release", 32'(req_ready), 32'd1);

      // single ENQ, minimum latency
      do_op(OP_ENQ, '{8'h20, 8'h01}, 1'b0, KV_EMPTY, 1, 0, 0, 0);
      do_op(OP_DEQ, KV_EMPTY, 1'b0, '{8'h20, 8'h01}, 0, 0, 0, 0);

      // ordering
      do_op(OP_ENQ, '{8'h30, 8'h03}, 1'b0, KV_EMPTY, 1, 0, 0, 0);
      do_op(OP_ENQ, '{8'h10, 8'h01}, 1'b0, KV_EMPTY, 2, 0, 0, 0);
      do_op(OP_ENQ, '{8'h20, 8'h02}, 1'b0, KV_EMPTY, 3, 0, 0, 0);
      do_op(OP_DEQ, KV_EMPTY, 1'b0, '{8'h10, 8'h01}, 2, 0, 0, 0);
      do_op(OP_DEQ, KV_EMPTY, 1'b0, '{8'h20, 8'h02}, 1, 0, 0, 0);
      do_op(OP_DEQ, KV_EMPTY, 1'b0, '{8'h30, 8'h03}, 0, 0, 0, 0);

      // DEQ on empty is rejected
      do_op(OP_DEQ, KV_EMPTY, 1'b1, '{8'hFF, 8'h00}, 0, 0, 0, 0);

      // fill to capacity
      for (int i = 0; i < 15; i++)
         do_op(OP_ENQ, '{8'(8'h40 + i), 8'(i)}, 1'b0, KV_EMPTY, i + 1, 0, 0, 0);
      do_op(OP_ENQ,  '{8'h50, 8'hAA}, 1'b1, KV_EMPTY, 15, 0, 0, 0);
      do_op(OP_REPL, '{8'h05, 8'h55}, 1'b0, '{8'h40, 8'h00}, 15, 0, 0, 0);
      do_op(OP_NOP,  '{8'h01, 8'h01}, 1'b0, KV_EMPTY, 15, 0, 0, 0);

      // stalls in ISSUE, WAIT and on the response channel
      do_op(OP_DEQ, KV_EMPTY, 1'b0, '{8'h05, 8'h55}, 14, 3, 3, 2);

      // reset while in WAIT
      req_valid = 1'b1; req_op = OP_ENQ; req_kv = '{8'h77, 8'h07};
      step;
      req_valid = 1'b0; req_op = OP_NOP; req_kv = KV_EMPTY;
      step;
      chk("midop_strobe", 32'(pq_enq), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midop_reset");
      @(negedge clk);
      rst_n = 1'b1;
      step;
      do_op(OP_ENQ, '{8'h21, 8'h02}, 1'b0, KV_EMPTY, 1, 0, 0, 0);
      do_op(OP_DEQ, KV_EMPTY, 1'b0, '{8'h21, 8'h02}, 0, 0, 0, 0);
`ifdef PQ_DRV_STATS_EN
      chk("stat_enq", 32'(stat_enq), 32'd1);
      chk("stat_deq", 32'(stat_deq), 32'd1);
      chk("stat_err", 32'(stat_err), 32'd0);
`endif

      repeat (3) step;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
